// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter in front of the async-FIFO write port (wclk domain).
// Optional almost-full gating of new grants: FIFO_WARB_AFULL_EN.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic                  wfull,
`ifdef FIFO_WARB_AFULL_EN
  input  logic                  afull,
`endif
  output logic [NREQ-1:0]       ready,
  output logic [NREQ-1:0]       gnt,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(BURST + 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(NREQ - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_gidx;
  logic [BW-1:0]   r_bcnt;

  logic            w_any;
  logic [PW-1:0]   w_sel;
  logic [NREQ-1:0] w_onehot;
  logic            w_grant_ok;
  logic            w_req_g;
  logic            w_winc;
  logic [PW-1:0]   w_next_ptr;

  // Search for the first active requester at or after r_ptr, wrapping
  always_comb begin
    int j;
    j     = 0;
    w_any = 1'b0;
    w_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!w_any && req[j]) begin
        w_any = 1'b1;
        w_sel = PW'(j);
      end
    end
  end

  assign w_onehot = NREQ'(1) << w_sel;

`ifdef FIFO_WARB_AFULL_EN
  assign w_grant_ok = w_any & ~afull;
`else
  assign w_grant_ok = w_any;
`endif

  assign w_req_g    = req[r_gidx];
  assign w_winc     = (r_state == S_GRANT) & w_req_g & ~wfull;
  assign w_next_ptr = (r_gidx == LAST_IDX) ? '0 : r_gidx + 1'b1;

  assign winc  = w_winc;
  assign gnt   = r_gnt;
  assign busy  = (r_state == S_GRANT);
  assign ready = ((r_state == S_GRANT) && !wfull) ? r_gnt : '0;
  assign wdata = (r_gnt == '0) ? '0 : req_data[r_gidx*DSIZE +: DSIZE];

  // Grant FSM: issue grant in IDLE, count beats and release in GRANT
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_bcnt  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_ok) begin
            r_gnt   <= w_onehot;
            r_gidx  <= w_sel;
            r_bcnt  <= '0;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!w_req_g || (w_winc && r_bcnt == LAST_BEAT)) begin
            r_gnt   <= '0;
            r_bcnt  <= '0;
            r_ptr   <= w_next_ptr;
            r_state <= S_IDLE;
          end else if (w_winc) begin
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: requester agents feed
// per-port word lists, expected FIFO words are queued in arrival order.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int BURST = 4;

  logic                  wclk = 1'b0;
  logic                  wrst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*DSIZE-1:0] req_data = '0;
  logic                  wfull = 1'b0;
  logic                  afull = 1'b0;
  logic [NREQ-1:0]       ready;
  logic [NREQ-1:0]       gnt;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  busy;

  fifo_wr_arbiter #(
    .NREQ (NREQ),
    .DSIZE(DSIZE),
    .BURST(BURST)
  ) dut (
    .wclk    (wclk),
    .wrst    (wrst),
    .req     (req),
    .req_data(req_data),
    .wfull   (wfull),
`ifdef FIFO_WARB_AFULL_EN
    .afull   (afull),
`endif
    .ready   (ready),
    .gnt     (gnt),
    .winc    (winc),
    .wdata   (wdata),
    .busy    (busy)
  );

  always #5 wclk = ~wclk;

  logic [7:0] amem[NREQ][16];
  int         ahead[NREQ];
  int         atail[NREQ];
  logic [7:0] sb[$];
  logic [3:0] glog[$];
  logic [3:0] prev_gnt = '0;
  int         cnt = 0;
  int         nx = 0;
  int         first_x = -1;
  int         last_x = -1;
  int         n_tot = 0;
  int         n_bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (ahead[i] < atail[i]);
      req_data[i*DSIZE +: DSIZE] = req[i] ? amem[i][ahead[i]] : 8'h00;
    end
  endtask

  task automatic load(int i, int n, logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      amem[i][atail[i]] = base + 8'(k);
      atail[i]++;
    end
    drive();
  endtask

  task automatic expect_words(logic [7:0] base, int n);
    for (int k = 0; k < n; k++) sb.push_back(base + 8'(k));
  endtask

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < NREQ; i++) if (ahead[i] < atail[i]) p = 1'b1;
    return p;
  endfunction

  task automatic clear_agents();
    for (int i = 0; i < NREQ; i++) begin
      ahead[i] = 0;
      atail[i] = 0;
    end
    sb.delete();
    drive();
  endtask

  // one clock: sample before the edge, advance agents after it
  task automatic cyc();
    logic [NREQ-1:0] rd;
    logic [NREQ-1:0] rq;
    #1;
    rd = ready;
    rq = req;
    chk("ready_1hot", 32'($countones(ready) <= 1), 1);
    chk("winc_vs_full", 32'(winc & wfull), 0);
    if (gnt == '0) chk("wdata_idle", 32'(wdata), 0);
    if (gnt != prev_gnt && gnt != '0) glog.push_back(gnt);
    prev_gnt = gnt;
    if (winc) begin
      if (sb.size() == 0) chk("sb_underrun", 32'(sb.size()), 1);
      else chk("wdata", 32'(wdata), 32'(sb.pop_front()));
      nx++;
      if (first_x < 0) first_x = cnt;
      last_x = cnt;
    end
    @(posedge wclk);
    cnt++;
    #1;
    if (!wrst)
      for (int i = 0; i < NREQ; i++)
        if (rd[i] && rq[i]) ahead[i]++;
    drive();
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    wfull = 1'b0;
    afull = 1'b0;
    clear_agents();
    repeat (2) cyc();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_winc", 32'(winc), 0);
    chk("rst_wdata", 32'(wdata), 0);
    wrst = 1'b0;
    cyc();
    glog.delete();
    first_x = -1;
    last_x = -1;
  endtask

  task automatic drain(string tag, int budget);
    int b;
    b = 0;
    while ((pending() || busy) && b < budget) begin
      cyc();
      b++;
    end
    chk({tag, "_timeout"}, 32'(b < budget), 1);
    chk({tag, "_sb_left"}, 32'(sb.size()), 0);
  endtask

  task automatic wait_xfer(string tag, int n);
    int b;
    int n0;
    b = 0;
    n0 = nx;
    while (nx - n0 < n && b < 50) begin
      cyc();
      b++;
    end
    chk({tag, "_wait"}, 32'(nx - n0), 32'(n));
  endtask

  initial begin
    int l;
    int n0;
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int l;
    int n0;
    clear_agents();
    do_reset();

    // reset mid-burst
    load(1, 4, 8'h40);
    expect_words(8'h40, 1);
    wait_xfer("t1", 1);
    #1;
    chk("t1_gnt_pre", 32'(gnt), 32'h2);
    #1;
    wrst = 1'b1;
    #1;
    chk("t1_gnt_rst", 32'(gnt), 0);
    chk("t1_winc_rst", 32'(winc), 0);
    chk("t1_ready_rst", 32'(ready), 0);
    clear_agents();
    repeat (2) cyc();
    wrst = 1'b0;
    cyc();
    glog.delete();
    load(0, 1, 8'h50);
    load(1, 1, 8'h51);
    expect_words(8'h50, 2);
    drain("t1", 40);
    chk("t1_ngrant", 32'(glog.size()), 2);
    if (glog.size() == 2) begin
      chk("t1_g0", 32'(glog[0]), 32'h1);
      chk("t1_g1", 32'(glog[1]), 32'h2);
    end

    // single requester, two bursts
    do_reset();
    n0 = nx;
    l = cnt;
    load(0, 8, 8'h10);
    expect_words(8'h10, 8);
    drain("t2", 60);
    chk("t2_words", 32'(nx - n0), 8);
    chk("t2_latency", 32'(first_x - l), 1);
    chk("t2_span", 32'(last_x - first_x), 8);
    chk("t2_ngrant", 32'(glog.size()), 2);

    // all requesters, strict round robin
    do_reset();
    load(0, 8, 8'h00);
    load(1, 4, 8'h20);
    load(2, 4, 8'h30);
    load(3, 4, 8'h40);
    expect_words(8'h00, 4);
    expect_words(8'h20, 4);
    expect_words(8'h30, 4);
    expect_words(8'h40, 4);
    expect_words(8'h04, 4);
    drain("t3", 100);
    chk("t3_span", 32'(last_x - first_x), 23);
    chk("t3_ngrant", 32'(glog.size()), 5);
    if (glog.size() == 5) begin
      chk("t3_g0", 32'(glog[0]), 32'h1);
      chk("t3_g1", 32'(glog[1]), 32'h2);
      chk("t3_g2", 32'(glog[2]), 32'h4);
      chk("t3_g3", 32'(glog[3]), 32'h8);
      chk("t3_g4", 32'(glog[4]), 32'h1);
    end

    // full stall during grant 2
    do_reset();
    n0 = nx;
    load(2, 4, 8'h60);
    expect_words(8'h60, 4);
    wait_xfer("t4", 1);
    wfull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_winc_full", 32'(winc), 0);
      chk("t4_ready_full", 32'(ready[2]), 0);
      chk("t4_gnt_full", 32'(gnt), 32'h4);
      cyc();
    end
    wfull = 1'b0;
    drain("t4", 40);
    chk("t4_words", 32'(nx - n0), 4);
    chk("t4_ngrant", 32'(glog.size()), 1);

    // requester drops early
    do_reset();
    load(1, 2, 8'h70);
    load(3, 2, 8'h80);
    expect_words(8'h70, 2);
    expect_words(8'h80, 2);
    drain("t5", 40);
    chk("t5_span", 32'(last_x - first_x), 5);
    chk("t5_ngrant", 32'(glog.size()), 2);
    if (glog.size() == 2) begin
      chk("t5_g0", 32'(glog[0]), 32'h2);
      chk("t5_g1", 32'(glog[1]), 32'h8);
    end

`ifdef FIFO_WARB_AFULL_EN
    // almost-full holds off new grants
    do_reset();
    afull = 1'b1;
    load(2, 1, 8'h90);
    expect_words(8'h90, 1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      chk("t6_gnt_afull", 32'(gnt), 0);
    end
    afull = 1'b0;
    cyc();
    #1;
    chk("t6_gnt", 32'(gnt), 32'h4);
    drain("t6", 20);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
